// File: rtl/if_prefetch.sv
// if_prefetch: in-order instruction prefetch buffer between a variable-latency instruction
// memory and the IF stage, with redirect flush and in-flight response discard.

module if_prefetch_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [CW-1:0] count,
    input  logic [CW-1:0] inflight,
    input  logic [CW-1:0] discard
);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CW'(DEPTH))));
    a_count_max: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight <= CW'(DEPTH));
    a_discard_max: assert property (@(posedge clk) disable iff (rst) discard <= inflight);
endmodule

module if_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] inflight_r;
    logic [CW-1:0] discard_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   fifo_inst_r [DEPTH];
    logic [31:0]   fifo_pc_r   [DEPTH];
    logic          inst_valid_r;
    logic [31:0]   inst_r;
    logic [31:0]   inst_pc_r;
    logic [31:0]   inst_pc4_r;

    logic [31:0]   target_s;
    logic [CW:0]   occupancy_s;
    logic          mem_req_s;
    logic          issue_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nx_s;
    logic [CW-1:0] inflight_nx_s;
    logic [CW-1:0] discard_nx_s;
    logic [31:0]   fetch_pc_nx_s;
    logic [31:0]   resp_pc_nx_s;
    logic [AW-1:0] wr_ptr_nx_s;
    logic [AW-1:0] rd_ptr_nx_s;
    logic [31:0]   head_inst_s;
    logic [31:0]   head_pc_s;

    // Request qualification and the per-cycle issue/response/pop events
    always_comb begin
        target_s    = redirect_addr & 32'hFFFF_FFFC;
        occupancy_s = {1'b0, count_r} + {1'b0, inflight_r};
        mem_req_s   = !rst && !redirect && (occupancy_s < DEPTH_W);
        issue_s     = mem_req_s && mem_ready;
        drop_s      = mem_rvalid && (discard_r != CNT_ZERO);
        push_s      = mem_rvalid && !drop_s && !redirect;
        pop_s       = inst_valid_r && inst_ready && !redirect;
    end

    // Next-state for counters, PCs, pointers and the head to present after this edge
    always_comb begin
        inflight_nx_s = inflight_r + CW'(issue_s) - CW'(mem_rvalid);
        count_nx_s    = count_r;
        discard_nx_s  = discard_r;
        fetch_pc_nx_s = fetch_pc_r;
        resp_pc_nx_s  = resp_pc_r;
        wr_ptr_nx_s   = wr_ptr_r;
        rd_ptr_nx_s   = rd_ptr_r;
        head_inst_s   = 32'd0;
        head_pc_s     = 32'd0;
        if (redirect) begin
            // every word still in flight after this edge belongs to the old path
            count_nx_s    = CNT_ZERO;
            discard_nx_s  = inflight_nx_s;
            fetch_pc_nx_s = target_s;
            resp_pc_nx_s  = target_s;
            wr_ptr_nx_s   = PTR_ZERO;
            rd_ptr_nx_s   = PTR_ZERO;
        end else begin
            count_nx_s    = count_r + CW'(push_s) - CW'(pop_s);
            discard_nx_s  = drop_s ? (discard_r - CNT_ONE) : discard_r;
            fetch_pc_nx_s = issue_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
            resp_pc_nx_s  = push_s ? (resp_pc_r + 32'd4) : resp_pc_r;
            wr_ptr_nx_s   = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_nx_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        end
        // a word pushed into an otherwise empty buffer bypasses storage to the head
        if (push_s && (count_nx_s == CNT_ONE)) begin
            head_inst_s = mem_rdata;
            head_pc_s   = resp_pc_r;
        end else begin
            head_inst_s = fifo_inst_r[rd_ptr_nx_s];
            head_pc_s   = fifo_pc_r[rd_ptr_nx_s];
        end
    end

    // State registers, FIFO storage and registered head outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r   <= 32'd0;
            resp_pc_r    <= 32'd0;
            count_r      <= CNT_ZERO;
            inflight_r   <= CNT_ZERO;
            discard_r    <= CNT_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'd0;
            inst_pc_r    <= 32'd0;
            inst_pc4_r   <= 32'd4;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_r[i] <= 32'd0;
                fifo_pc_r[i]   <= 32'd0;
            end
        end else begin
            fetch_pc_r   <= fetch_pc_nx_s;
            resp_pc_r    <= resp_pc_nx_s;
            count_r      <= count_nx_s;
            inflight_r   <= inflight_nx_s;
            discard_r    <= discard_nx_s;
            wr_ptr_r     <= wr_ptr_nx_s;
            rd_ptr_r     <= rd_ptr_nx_s;
            inst_valid_r <= (count_nx_s != CNT_ZERO);
            inst_r       <= head_inst_s;
            inst_pc_r    <= head_pc_s;
            inst_pc4_r   <= head_pc_s + 32'd4;
            if (push_s) begin
                fifo_inst_r[wr_ptr_r] <= mem_rdata;
                fifo_pc_r[wr_ptr_r]   <= resp_pc_r;
            end
        end
    end

    assign mem_req    = mem_req_s;
    assign mem_addr   = fetch_pc_r;
    assign inst_valid = inst_valid_r;
    assign inst       = inst_r;
    assign inst_pc    = inst_pc_r;
    assign inst_pc4   = inst_pc4_r;

    if_prefetch_checker #(.DEPTH(DEPTH), .CW(CW)) u_checker (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .count    (count_r),
        .inflight (inflight_r),
        .discard  (discard_r)
    );
endmodule
